// File: rtl/spi_pkt_reader.sv
// spi_pkt_reader
//   SPI master (mode 0, MSB first) that reads one packet from the packet
//   receiver's SPI slave. Each byte is read in its own chip-select frame,
//   and cmd_byte is sent on MOSI in every frame. Raising CS between frames
//   moves the slave on to its next byte.
//
//   Parameters
//     CLK_DIV : clk cycles per SCK half-period (>= 2)
//     NBYTES  : bytes per packet (1..16)
//     GAP     : clk cycles CS stays high between frames (>= 2)
//
//   Ports
//     clk      in   system clock
//     rst      in   asynchronous, active-high reset
//     start    in   one-cycle request, only looked at in IDLE
//     cmd_byte in   byte sent on MOSI, captured when start is accepted
//     MISO     in   serial data from the slave
//     SCK      out  SPI clock, idles low
//     CS       out  chip select, active low
//     MOSI     out  serial data to the slave
//     busy     out  high while a packet is in progress
//     done     out  one-cycle pulse when pkt_out is updated
//     pkt_out  out  received packet, first byte in the MSBs
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; CS high, SCK low
//   SETUP | CS low, SCK low for one half-period; MOSI already holds bit 7
//   SHIFT | SCK toggling; 8 clock pulses, then one trailing low half-period
//   HOLD  | CS low, SCK low for one half-period; byte stored on exit
//   GAP   | CS high for GAP cycles; then next frame or finish the packet
module spi_pkt_reader #(
    parameter int CLK_DIV = 4,
    parameter int NBYTES  = 8,
    parameter int GAP     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            cmd_byte,
    input  logic                  MISO,
    output logic                  SCK,
    output logic                  CS,
    output logic                  MOSI,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   pkt_out
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [3:0]       BYTE_LAST = 4'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div_cnt, div_cnt_n;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
    logic [4:0]          tog_cnt, tog_cnt_n;
    logic [3:0]          byte_cnt, byte_cnt_n;
    logic [7:0]          cmd_reg, cmd_reg_n;
    logic [6:0]          tx_sr, tx_sr_n;
    logic [7:0]          rx_sr, rx_sr_n;
    logic [8*NBYTES-1:0] asm_reg, asm_reg_n;
    logic [8*NBYTES-1:0] pkt_out_n;
    logic                sck_n, cs_n, mosi_n, busy_n, done_n;
    logic                div_tick;
    logic [DIV_W-1:0]    div_adv;

    assign div_tick = (div_cnt == DIV_LAST);
    assign div_adv  = div_tick ? '0 : div_cnt + DIV_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            tog_cnt  <= '0;
            byte_cnt <= '0;
            cmd_reg  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            asm_reg  <= '0;
            pkt_out  <= '0;
            SCK      <= 1'b0;
            CS       <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_cnt_n;
            gap_cnt  <= gap_cnt_n;
            tog_cnt  <= tog_cnt_n;
            byte_cnt <= byte_cnt_n;
            cmd_reg  <= cmd_reg_n;
            tx_sr    <= tx_sr_n;
            rx_sr    <= rx_sr_n;
            asm_reg  <= asm_reg_n;
            pkt_out  <= pkt_out_n;
            SCK      <= sck_n;
            CS       <= cs_n;
            MOSI     <= mosi_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_cnt_n  = div_cnt;
        gap_cnt_n  = gap_cnt;
        tog_cnt_n  = tog_cnt;
        byte_cnt_n = byte_cnt;
        cmd_reg_n  = cmd_reg;
        tx_sr_n    = tx_sr;
        rx_sr_n    = rx_sr;
        asm_reg_n  = asm_reg;
        pkt_out_n  = pkt_out;
        sck_n      = SCK;
        cs_n       = CS;
        mosi_n     = MOSI;
        busy_n     = busy;
        done_n     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cmd_reg_n  = cmd_byte;
                    tx_sr_n    = cmd_byte[6:0];
                    mosi_n     = cmd_byte[7];
                    byte_cnt_n = '0;
                    div_cnt_n  = '0;
                    cs_n       = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = S_SETUP;
                end
            end

            // The first rising SCK edge is issued on the SETUP exit edge,
            // so it counts as toggle 1 of 16.
            S_SETUP: begin
                div_cnt_n = div_adv;
                if (div_tick) begin
                    sck_n     = 1'b1;
                    rx_sr_n   = {rx_sr[6:0], MISO};
                    tog_cnt_n = 5'd1;
                    state_n   = S_SHIFT;
                end
            end

            // After the 16th toggle SCK stays low for one more half-period
            // before HOLD, which makes the CS-low window 18 half-periods.
            S_SHIFT: begin
                div_cnt_n = div_adv;
                if (div_tick) begin
                    if (tog_cnt == 5'd16) begin
                        state_n = S_HOLD;
                    end else begin
                        sck_n     = ~SCK;
                        tog_cnt_n = tog_cnt + 5'd1;
                        if (!SCK) begin
                            rx_sr_n = {rx_sr[6:0], MISO};
                        end else if (tog_cnt != 5'd15) begin
                            // The last falling edge leaves MOSI on bit 0.
                            mosi_n  = tx_sr[6];
                            tx_sr_n = {tx_sr[5:0], 1'b0};
                        end
                    end
                end
            end

            S_HOLD: begin
                div_cnt_n = div_adv;
                if (div_tick) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (byte_cnt == 4'(k)) begin
                            asm_reg_n[8*(NBYTES-k)-1 -: 8] = rx_sr;
                        end
                    end
                    cs_n      = 1'b1;
                    gap_cnt_n = '0;
                    div_cnt_n = '0;
                    state_n   = S_GAP;
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    div_cnt_n = '0;
                    if (byte_cnt == BYTE_LAST) begin
                        pkt_out_n = asm_reg;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        state_n   = S_IDLE;
                    end else begin
                        byte_cnt_n = byte_cnt + 4'd1;
                        tx_sr_n    = cmd_reg[6:0];
                        mosi_n     = cmd_reg[7];
                        cs_n       = 1'b0;
                        state_n    = S_SETUP;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/spi_pkt_reader.md
# spi_pkt_reader

SPI master that drains one captured packet from the receiver's SPI slave, one byte per chip-select frame. A `start` pulse runs `NBYTES` mode-0 byte frames, sends `cmd_byte` on MOSI in each frame and assembles the MISO bytes into `pkt_out`. CS is deasserted between frames so that the slave-side FSM advances to the next byte. It sits on the host/test side of the SPI link, facing `SCK`/`CS`/`MOSI`/`MISO` of the packet receiver.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period; legal ≥2.
- `NBYTES`, 8: bytes per packet; legal 1..16.
- `GAP`, 4: `clk` cycles CS is held high between frames; legal ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `cmd_byte`  in  8  byte to transmit on MOSI; captured when `start` is accepted.
- `MISO`  in  1  serial data from slave; sampled on SCK rising edge.
- `SCK`  out  1  SPI clock, CPOL=0.
- `CS`  out  1  chip select, active-low.
- `MOSI`  out  1  serial data to slave, MSB first.
- `busy`  out  1  high from the accept edge until the `done` edge.
- `done`  out  1  one-cycle pulse when `pkt_out` becomes valid.
- `pkt_out`  out  8*NBYTES  received packet; first byte in the MSBs.

## Operation
- Reset values: `SCK`=0, `CS`=1, `MOSI`=0, `busy`=0, `done`=0, `pkt_out`=0, FSM=IDLE, all counters 0.
- All outputs are registered. Mode 0 (CPOL=0, CPHA=0). Both directions are MSB first.
- FSM states:
  - IDLE: on `start`, latch `cmd_byte`, byte_cnt=0, `CS`←0, `busy`←1, `MOSI`←cmd[7], go to SETUP.
  - SETUP: CS low, SCK low for `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: toggle SCK every `CLK_DIV` cycles, 16 toggles total.
    - Rising toggle: `rx_sr` ← {`rx_sr`[6:0], `MISO`}. Sample `MISO` on the same clk edge that drives SCK to 1.
    - Falling toggle: `MOSI` ← next cmd bit.
    - After the 8th falling toggle, go to HOLD. `MOSI` keeps the last bit.
  - HOLD: SCK low, CS low for `CLK_DIV` cycles. On exit, write `rx_sr` into byte slot `byte_cnt` of the assembly register, `CS`←1, go to GAP.
  - GAP: CS high for `GAP` cycles.
    - If byte_cnt == NBYTES-1: copy the assembly register to `pkt_out`, pulse `done`, drop `busy`, go to IDLE.
    - Otherwise: byte_cnt+1, `CS`←0, `MOSI`←cmd[7], go to SETUP.
- Byte k (k=0 first) lands in `pkt_out`[8*(NBYTES-k)-1 -: 8].
- `pkt_out` changes only on the `done` edge and holds its value until the next `done`.
- `start` while `busy`=1 is ignored. No queueing.
- `start` on the same edge as `done` (FSM leaving GAP) is ignored. `start` is accepted the next cycle.
- `rst` mid-packet: all outputs take their reset values immediately. The partial packet is discarded, no `done`, `pkt_out` cleared.
- byte_cnt is 4 bits. A `CLK_DIV` counter wraps at `CLK_DIV`-1. A `GAP` counter is sized by $clog2.

## Timing
- `start` is high at edge 0 and accepted. Then:
  - `busy`=1 and `CS`=0 from edge 1.
  - First SCK rising edge at edge 1+CLK_DIV.
  - SCK rising edges recur every 2*CLK_DIV cycles.
- One frame: `CS` low for exactly 18*CLK_DIV cycles, then high for exactly `GAP` cycles.
- `done` is high for one cycle at edge 1+NBYTES*(18*CLK_DIV+GAP). `busy` falls on that same edge.
- Defaults: CS low for 72 cycles per byte, 76 cycles per frame, `done` at edge 609.
- MOSI is stable ≥CLK_DIV cycles before every SCK rise. MOSI changes only in the cycle SCK falls, or while CS is high.
- SCK is always 0 while CS=1, and on every CS transition.

## Test plan
- Defaults, slave model returns 0x11,0x22,…,0x88 on successive frames, `start` at edge 0 → `done` exactly at edge 609 and `pkt_out`=0x1122334455667788. Exactly 8 CS low pulses of 72 cycles each, 64 SCK rising edges.
- `cmd_byte`=0xA5, MOSI monitor sampling on SCK rise → reads 0xA5 in every one of the 8 frames. MOSI is never changed while SCK=1.
- `start` re-pulsed at edges 10 and 300, and again on the `done` edge → all ignored, single `done`. A `start` one cycle after `done` begins a new packet with CS low one edge later.
- `rst` asserted at edge 200 (mid byte 2) → CS=1, SCK=0, `busy`=0, `pkt_out`=0 immediately. No `done`. A fresh `start` then yields a correct full packet.
- CLK_DIV=2, GAP=2, NBYTES=1, MISO tied 1 → `done` at edge 1+1*(36+2)=39, `pkt_out`=0xFF. CS high gap measured as 2 cycles min.
- MISO tied 0 after a previous 0xFF packet → next `pkt_out`=0x00, so no stale bits are retained.
